// File: rtl/axioma_dmem_pkg.sv
// ============================================================================
// Module      : axioma_dmem_pkg
// Description : Shared types and constants for the AxiomaCore data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axioma_dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } dmem_state_t;

    localparam logic c_GNT_CPU = 1'b0;
    localparam logic c_GNT_DBG = 1'b1;

    // Range check done in 32 bits so base+depth cannot wrap at the address width.
    function automatic logic addr_in_window(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input logic [31:0] depth);
        return (addr >= base) && (addr < (base + depth));
    endfunction

endpackage

`default_nettype wire

// File: rtl/axioma_rr_arb2.sv
// ============================================================================
// Module      : axioma_rr_arb2
// Description : Two-requester round-robin picker; on contention the master not
//               granted last wins. Output is meaningful only when req != 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axioma_rr_arb2
    import axioma_dmem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt
);

    always_comb begin
        gnt = c_GNT_CPU;
        if (&req) begin
            gnt = ~last;
        end else if (req[1]) begin
            gnt = c_GNT_DBG;
        end
    end

endmodule

`default_nettype wire

// File: rtl/axioma_dmem_arbiter.sv
// ============================================================================
// Module      : axioma_dmem_arbiter
// Description : CPU / debug-port arbiter in front of the synchronous data SRAM,
//               with latency wait states and a one-cycle ready pulse per access.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axioma_dmem_arbiter
    import axioma_dmem_pkg::*;
#(
    parameter int                ADDR_W      = 16,
    parameter int                DATA_W      = 8,
    parameter logic [ADDR_W-1:0] MEM_BASE    = 16'h0100,
    parameter int                MEM_DEPTH   = 2048,
    parameter int                MEM_LATENCY = 1,
    localparam int               MEM_AW      = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic              dbg_rd,
    input  logic              dbg_wr,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              grant_dbg
);

    localparam int                 c_CNT_W     = $clog2(MEM_LATENCY + 1);
    localparam logic [c_CNT_W-1:0] c_WAIT_LOAD = c_CNT_W'(MEM_LATENCY);
    localparam logic [c_CNT_W-1:0] c_WAIT_LAST = c_CNT_W'(1);

    dmem_state_t         r_state;
    dmem_state_t         w_state_nxt;
    logic                r_last;
    logic                r_gnt;
    logic                r_write;
    logic                r_in_range;
    logic [MEM_AW-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_cpu_rdata;
    logic [DATA_W-1:0]   r_dbg_rdata;
    logic [c_CNT_W-1:0]  r_wait_cnt;

    logic                w_cpu_req;
    logic                w_dbg_req;
    logic                w_gnt;
    logic                w_sel_write;
    logic                w_sel_in_range;
    logic                w_wait_last;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;

    assign w_cpu_req = cpu_rd | cpu_wr;
    assign w_dbg_req = dbg_rd | dbg_wr;

    axioma_rr_arb2 u_arb (
        .req  ({w_dbg_req, w_cpu_req}),
        .last (r_last),
        .gnt  (w_gnt)
    );

    // A write request takes precedence when rd and wr are both high.
    assign w_sel_addr     = (w_gnt == c_GNT_DBG) ? dbg_addr  : cpu_addr;
    assign w_sel_wdata    = (w_gnt == c_GNT_DBG) ? dbg_wdata : cpu_wdata;
    assign w_sel_write    = (w_gnt == c_GNT_DBG) ? dbg_wr    : cpu_wr;
    assign w_sel_in_range = addr_in_window(32'(w_sel_addr), 32'(MEM_BASE), 32'(MEM_DEPTH));
    assign w_wait_last    = (r_wait_cnt == c_WAIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_last      <= c_GNT_DBG;
            r_gnt       <= c_GNT_CPU;
            r_write     <= 1'b0;
            r_in_range  <= 1'b0;
            r_mem_addr  <= '0;
            r_wdata     <= '0;
            r_cpu_rdata <= '0;
            r_dbg_rdata <= '0;
            r_wait_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_cpu_req || w_dbg_req) begin
                        r_gnt      <= w_gnt;
                        r_last     <= w_gnt;
                        r_write    <= w_sel_write;
                        r_in_range <= w_sel_in_range;
                        r_mem_addr <= MEM_AW'(w_sel_addr - MEM_BASE);
                        r_wdata    <= w_sel_wdata;
                    end
                end
                ST_ACCESS: begin
                    r_wait_cnt <= c_WAIT_LOAD;
                end
                ST_WAIT: begin
                    r_wait_cnt <= r_wait_cnt - c_WAIT_LAST;
                    if (w_wait_last && !r_write) begin
                        if (r_gnt == c_GNT_DBG) begin
                            r_dbg_rdata <= r_in_range ? mem_rdata : '0;
                        end else begin
                            r_cpu_rdata <= r_in_range ? mem_rdata : '0;
                        end
                    end
                end
                ST_RESP: begin
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:   if (w_cpu_req || w_dbg_req) w_state_nxt = ST_ACCESS;
            ST_ACCESS: w_state_nxt = ST_WAIT;
            ST_WAIT:   if (w_wait_last) w_state_nxt = ST_RESP;
            ST_RESP:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Out-of-window accesses keep the SRAM strobe low but run the same timing.
    assign mem_en    = (r_state == ST_ACCESS) && r_in_range;
    assign mem_we    = (r_state == ST_ACCESS) && r_in_range && r_write;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_wdata;
    assign cpu_rdata = r_cpu_rdata;
    assign dbg_rdata = r_dbg_rdata;
    assign cpu_ready = (r_state == ST_RESP) && (r_gnt == c_GNT_CPU);
    assign dbg_ready = (r_state == ST_RESP) && (r_gnt == c_GNT_DBG);
    assign busy      = (r_state != ST_IDLE);
    assign grant_dbg = r_gnt;

endmodule

`default_nettype wire

// File: tb/tb_axioma_dmem_arbiter.sv
// ============================================================================
// Module      : tb_axioma_dmem_arbiter
// Description : Self-checking bench for axioma_dmem_arbiter (latency 1 and 3).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axioma_dmem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // DUT A: MEM_LATENCY = 1
    logic [15:0] a_cpu_addr, a_dbg_addr;
    logic [7:0]  a_cpu_wdata, a_dbg_wdata, a_cpu_rdata, a_dbg_rdata;
    logic        a_cpu_rd, a_cpu_wr, a_dbg_rd, a_dbg_wr, a_cpu_ready, a_dbg_ready;
    logic        a_mem_en, a_mem_we, a_busy, a_grant_dbg;
    logic [10:0] a_mem_addr;
    logic [7:0]  a_mem_wdata, a_mem_rdata;

    // DUT B: MEM_LATENCY = 3
    logic [15:0] b_cpu_addr, b_dbg_addr;
    logic [7:0]  b_cpu_wdata, b_dbg_wdata, b_cpu_rdata, b_dbg_rdata;
    logic        b_cpu_rd, b_cpu_wr, b_dbg_rd, b_dbg_wr, b_cpu_ready, b_dbg_ready;
    logic        b_mem_en, b_mem_we, b_busy, b_grant_dbg;
    logic [10:0] b_mem_addr;
    logic [7:0]  b_mem_wdata, b_mem_rdata;

    axioma_dmem_arbiter #(.MEM_LATENCY(1)) u_dut_a (
        .clk(clk), .reset(reset),
        .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata), .cpu_rd(a_cpu_rd), .cpu_wr(a_cpu_wr),
        .cpu_rdata(a_cpu_rdata), .cpu_ready(a_cpu_ready),
        .dbg_addr(a_dbg_addr), .dbg_wdata(a_dbg_wdata), .dbg_rd(a_dbg_rd), .dbg_wr(a_dbg_wr),
        .dbg_rdata(a_dbg_rdata), .dbg_ready(a_dbg_ready),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
        .busy(a_busy), .grant_dbg(a_grant_dbg)
    );

    axioma_dmem_arbiter #(.MEM_LATENCY(3)) u_dut_b (
        .clk(clk), .reset(reset),
        .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata), .cpu_rd(b_cpu_rd), .cpu_wr(b_cpu_wr),
        .cpu_rdata(b_cpu_rdata), .cpu_ready(b_cpu_ready),
        .dbg_addr(b_dbg_addr), .dbg_wdata(b_dbg_wdata), .dbg_rd(b_dbg_rd), .dbg_wr(b_dbg_wr),
        .dbg_rdata(b_dbg_rdata), .dbg_ready(b_dbg_ready),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
        .busy(b_busy), .grant_dbg(b_grant_dbg)
    );

    // SRAM models; unused read cycles return X so mistimed captures show up.
    logic [7:0] mem_a [0:2047];
    logic [7:0] mem_b [0:2047];
    logic [7:0] pipe_a;
    logic [7:0] pipe_b [0:2];

    always @(posedge clk) begin
        if (a_mem_en && a_mem_we) mem_a[a_mem_addr] <= a_mem_wdata;
        pipe_a <= (a_mem_en && !a_mem_we) ? mem_a[a_mem_addr] : 8'hxx;
        if (b_mem_en && b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;
        pipe_b[0] <= (b_mem_en && !b_mem_we) ? mem_b[b_mem_addr] : 8'hxx;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign a_mem_rdata = pipe_a;
    assign b_mem_rdata = pipe_b[2];

    typedef struct packed {
        logic       dbg;
        logic       rd;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;

    always @(negedge clk) begin
        if (a_cpu_ready || a_dbg_ready) begin
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL a_unexpected_ready: cyc=%0d cpu_ready=%0b dbg_ready=%0b required no ready",
                         cyc, a_cpu_ready, a_dbg_ready);
            end else begin
                ea = q_a.pop_front();
                if (a_cpu_ready === a_dbg_ready || a_dbg_ready !== ea.dbg || cyc != ea.cyc ||
                    (ea.rd && ((ea.dbg ? a_dbg_rdata : a_cpu_rdata) !== ea.data))) begin
                    errors++;
                    $display("FAIL a_ready: cyc=%0d cpu_ready=%0b dbg_ready=%0b cpu_rdata=%h dbg_rdata=%h required cyc=%0d dbg=%0b rd=%0b data=%h",
                             cyc, a_cpu_ready, a_dbg_ready, a_cpu_rdata, a_dbg_rdata, ea.cyc, ea.dbg, ea.rd, ea.data);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (b_cpu_ready || b_dbg_ready) begin
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL b_unexpected_ready: cyc=%0d cpu_ready=%0b dbg_ready=%0b required no ready",
                         cyc, b_cpu_ready, b_dbg_ready);
            end else begin
                eb = q_b.pop_front();
                if (b_cpu_ready === b_dbg_ready || b_dbg_ready !== eb.dbg || cyc != eb.cyc ||
                    (eb.rd && ((eb.dbg ? b_dbg_rdata : b_cpu_rdata) !== eb.data))) begin
                    errors++;
                    $display("FAIL b_ready: cyc=%0d cpu_ready=%0b dbg_ready=%0b cpu_rdata=%h dbg_rdata=%h required cyc=%0d dbg=%0b rd=%0b data=%h",
                             cyc, b_cpu_ready, b_dbg_ready, b_cpu_rdata, b_dbg_rdata, eb.cyc, eb.dbg, eb.rd, eb.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        a_cpu_addr = '0; a_cpu_wdata = '0; a_cpu_rd = 0; a_cpu_wr = 0;
        a_dbg_addr = '0; a_dbg_wdata = '0; a_dbg_rd = 0; a_dbg_wr = 0;
        b_cpu_addr = '0; b_cpu_wdata = '0; b_cpu_rd = 0; b_cpu_wr = 0;
        b_dbg_addr = '0; b_dbg_wdata = '0; b_dbg_rd = 0; b_dbg_wr = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clr_inputs();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({a_busy, a_cpu_ready, a_dbg_ready, a_cpu_rdata, a_dbg_rdata, a_mem_en, a_mem_we,
             a_mem_addr, a_mem_wdata, a_grant_dbg} !== 41'd0) begin
            errors++;
            $display("FAIL reset_a: busy=%b rdy=%b%b rdata=%h/%h en=%b we=%b addr=%h wd=%h gd=%b required all 0",
                     a_busy, a_cpu_ready, a_dbg_ready, a_cpu_rdata, a_dbg_rdata, a_mem_en, a_mem_we,
                     a_mem_addr, a_mem_wdata, a_grant_dbg);
        end
        checks++;
        if ({b_busy, b_cpu_ready, b_dbg_ready, b_cpu_rdata, b_dbg_rdata, b_mem_en, b_mem_we,
             b_mem_addr, b_mem_wdata, b_grant_dbg} !== 41'd0) begin
            errors++;
            $display("FAIL reset_b: busy=%b en=%b addr=%h gd=%b required all 0",
                     b_busy, b_mem_en, b_mem_addr, b_grant_dbg);
        end
    endtask

    task automatic test_cpu_read();
        int c0;
        mem_a[5] = 8'h42;
        a_cpu_addr = 16'h0105; a_cpu_rd = 1'b1;
        c0 = cyc;
        q_a.push_back('{1'b0, 1'b1, 8'h42, c0 + 3});
        step();
        checks++;
        if (a_mem_en !== 1'b1 || a_mem_we !== 1'b0 || a_mem_addr !== 11'h005 || a_grant_dbg !== 1'b0) begin
            errors++;
            $display("FAIL cpu_read_access: en=%b we=%b addr=%h gd=%b required en=1 we=0 addr=005 gd=0",
                     a_mem_en, a_mem_we, a_mem_addr, a_grant_dbg);
        end
        step();
        checks++;
        if (a_mem_en !== 1'b0 || a_busy !== 1'b1) begin
            errors++;
            $display("FAIL cpu_read_wait: en=%b busy=%b required en=0 busy=1", a_mem_en, a_busy);
        end
        step();
        checks++;
        if (a_cpu_ready !== 1'b1 || a_dbg_ready !== 1'b0) begin
            errors++;
            $display("FAIL cpu_read_resp: cpu_ready=%b dbg_ready=%b required 1/0", a_cpu_ready, a_dbg_ready);
        end
        step();
        a_cpu_rd = 1'b0;
        checks++;
        if (a_busy !== 1'b0) begin
            errors++;
            $display("FAIL cpu_read_idle: busy=%b required 0", a_busy);
        end
        step();
    endtask

    task automatic test_contention();
        int c0;
        do_reset();
        a_cpu_addr = 16'h0100; a_cpu_wdata = 8'hAA; a_cpu_wr = 1'b1;
        a_dbg_addr = 16'h0101; a_dbg_wdata = 8'h55; a_dbg_wr = 1'b1;
        c0 = cyc;
        q_a.push_back('{1'b0, 1'b0, 8'h00, c0 + 3});
        q_a.push_back('{1'b1, 1'b0, 8'h00, c0 + 7});
        step();
        checks++;
        if (a_mem_en !== 1'b1 || a_mem_we !== 1'b1 || a_mem_addr !== 11'h000 ||
            a_mem_wdata !== 8'hAA || a_grant_dbg !== 1'b0) begin
            errors++;
            $display("FAIL contention_cpu: en=%b we=%b addr=%h wd=%h gd=%b required 1 1 000 aa 0",
                     a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata, a_grant_dbg);
        end
        step(); step(); step();
        a_cpu_wr = 1'b0;
        step();
        checks++;
        if (a_mem_en !== 1'b1 || a_mem_we !== 1'b1 || a_mem_addr !== 11'h001 ||
            a_mem_wdata !== 8'h55 || a_grant_dbg !== 1'b1) begin
            errors++;
            $display("FAIL contention_dbg: en=%b we=%b addr=%h wd=%h gd=%b required 1 1 001 55 1",
                     a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata, a_grant_dbg);
        end
        step(); step(); step();
        a_dbg_wr = 1'b0;
        checks++;
        if (mem_a[0] !== 8'hAA || mem_a[1] !== 8'h55) begin
            errors++;
            $display("FAIL contention_mem: mem[0]=%h mem[1]=%h required aa 55", mem_a[0], mem_a[1]);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int c0;
        mem_a[2] = 8'h11; mem_a[3] = 8'h22;
        a_cpu_addr = 16'h0102; a_cpu_rd = 1'b1;
        a_dbg_addr = 16'h0103; a_dbg_rd = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 4; i++) begin
            q_a.push_back('{i[0], 1'b1, (i[0] ? 8'h22 : 8'h11), c0 + 4 * i + 3});
        end
        for (int j = 1; j < 16; j++) begin
            step();
            if ((j % 4) == 1) begin
                checks++;
                if (a_mem_en !== 1'b1 || a_grant_dbg !== ((j / 4) % 2 == 1)) begin
                    errors++;
                    $display("FAIL back_to_back_grant%0d: en=%b gd=%b required en=1 gd=%0d",
                             j / 4, a_mem_en, a_grant_dbg, (j / 4) % 2);
                end
            end
        end
        step();
        a_cpu_rd = 1'b0; a_dbg_rd = 1'b0;
        step();
    endtask

    task automatic test_out_of_window();
        int c0;
        a_cpu_addr = 16'h0050; a_cpu_rd = 1'b1;
        c0 = cyc;
        q_a.push_back('{1'b0, 1'b1, 8'h00, c0 + 3});
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (a_mem_en !== 1'b0) begin
                errors++;
                $display("FAIL oow_read_en: cyc=%0d en=%b required 0", cyc, a_mem_en);
            end
        end
        step();
        a_cpu_rd = 1'b0;
        checks++;
        if (a_dbg_rdata !== 8'h22) begin
            errors++;
            $display("FAIL dbg_rdata_hold: dbg_rdata=%h required 22", a_dbg_rdata);
        end
        a_cpu_addr = 16'h0900; a_cpu_wdata = 8'h77; a_cpu_wr = 1'b1;
        c0 = cyc;
        q_a.push_back('{1'b0, 1'b0, 8'h00, c0 + 3});
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (a_mem_en !== 1'b0) begin
                errors++;
                $display("FAIL oow_write_en: cyc=%0d en=%b required 0", cyc, a_mem_en);
            end
        end
        step();
        a_cpu_wr = 1'b0;
        checks++;
        if (mem_a[0] !== 8'hAA) begin
            errors++;
            $display("FAIL oow_write_dropped: mem[0]=%h required aa", mem_a[0]);
        end
        step();
    endtask

    task automatic test_latency3();
        int c0;
        mem_b[11'h7FF] = 8'h5A;
        b_dbg_addr = 16'h08FF; b_dbg_rd = 1'b1;
        c0 = cyc;
        q_b.push_back('{1'b1, 1'b1, 8'h5A, c0 + 5});
        step();
        checks++;
        if (b_mem_en !== 1'b1 || b_mem_we !== 1'b0 || b_mem_addr !== 11'h7FF || b_grant_dbg !== 1'b1) begin
            errors++;
            $display("FAIL lat3_access: en=%b we=%b addr=%h gd=%b required 1 0 7ff 1",
                     b_mem_en, b_mem_we, b_mem_addr, b_grant_dbg);
        end
        step(); step(); step(); step();
        checks++;
        if (b_dbg_ready !== 1'b1 || b_dbg_rdata !== 8'h5A || b_cpu_ready !== 1'b0) begin
            errors++;
            $display("FAIL lat3_resp: dbg_ready=%b dbg_rdata=%h cpu_ready=%b required 1 5a 0",
                     b_dbg_ready, b_dbg_rdata, b_cpu_ready);
        end
        step();
        b_dbg_rd = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        int c0;
        mem_a[4] = 8'h3C;
        a_cpu_addr = 16'h0104; a_cpu_rd = 1'b1;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (a_busy !== 1'b0 || a_cpu_ready !== 1'b0 || a_dbg_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b cpu_ready=%b dbg_ready=%b required 0 0 0",
                     a_busy, a_cpu_ready, a_dbg_ready);
        end
        c0 = cyc;
        q_a.push_back('{1'b0, 1'b1, 8'h3C, c0 + 3});
        step();
        checks++;
        if (a_mem_en !== 1'b1 || a_mem_addr !== 11'h004) begin
            errors++;
            $display("FAIL reset_mid_retry: en=%b addr=%h required 1 004", a_mem_en, a_mem_addr);
        end
        step(); step(); step();
        a_cpu_rd = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1;
        clr_inputs();
        test_reset();
        test_cpu_read();
        test_contention();
        test_back_to_back();
        test_out_of_window();
        test_latency3();
        test_reset_mid();
        step(); step();
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL missing_ready: pending_a=%0d pending_b=%0d required 0 0", q_a.size(), q_b.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
